// File: rtl/seq_addsub_if.sv
// Handshake and data bundle for seq_addsub.
// master: the producer/consumer side that drives operands and takes results.
// slave:  the sequential add/subtract unit.
interface seq_addsub_if #(
  parameter int WIDTH = 20
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, mode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, mode, op_a, op_b, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor that processes CHUNK bits per
// cycle, LSB slice first, with a valid/ready handshake on both sides.
// mode 0 computes op_b + op_a; mode 1 computes op_b - op_a as
// op_b + ~op_a + 1. Flags: cout (carry out of MSB, 1 = no borrow on
// subtract), ovf (signed overflow), zero (final result is 0).
// Optional feature: define SEQ_ADDSUB_SATURATE_EN to clamp the result to
// the signed max/min on overflow; otherwise the result wraps modulo 2^WIDTH.
module seq_addsub #(
  parameter int WIDTH = 20,
  parameter int CHUNK = 5
) (
  input  logic         clk,
  input  logic         rst,
  seq_addsub_if.slave  bus
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;      // effective second operand (op_a or ~op_a)
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] res_final;
  logic             ovf_full;

  // Slice adder, assembled full-width result, overflow and optional clamp.
  always_comb begin
    slice_sum = {1'b0, b_q[int'(cnt_q)*CHUNK +: CHUNK]}
              + {1'b0, a_q[int'(cnt_q)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_full = res_q;
    res_full[int'(cnt_q)*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    ovf_full = (b_q[WIDTH-1] == a_q[WIDTH-1]) && (res_full[WIDTH-1] != b_q[WIDTH-1]);
`ifdef SEQ_ADDSUB_SATURATE_EN
    if (ovf_full) begin
      res_final = b_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      res_final = res_full;
    end
`else
    res_final = res_full;
`endif
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = bus.mode;
          a_d     = bus.mode ? ~bus.op_a : bus.op_a;
          b_d     = bus.op_b;
          res_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
        end
      end
      RUN: begin
        res_d   = res_full;
        carry_d = slice_sum[CHUNK];
        if (cnt_q == LAST_SLICE) begin
          // Flags and clamp land on the same edge that enters DONE.
          state_d = DONE;
          res_d   = res_final;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = ovf_full;
          zero_d  = (res_final == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed testbench for seq_addsub at WIDTH=20, CHUNK=5.
// Expected values are hand-computed; saturation expectations follow
// SEQ_ADDSUB_SATURATE_EN when the bench is built with that macro.
module tb_seq_addsub;

  localparam int W = 20;
  localparam int C = 5;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  seq_addsub_if #(.WIDTH(W)) bus ();

  seq_addsub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid after an accepting edge; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // Present one operation in IDLE, accept it, and wait for the result.
  task automatic do_op(input logic m, input logic [W-1:0] b, input logic [W-1:0] a,
                       output int lat);
    bus.mode      = m;
    bus.op_b      = b;
    bus.op_a      = a;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_done(lat);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+4:0] got;
    rst = 1'b1;
    tick();
    tick();
    got = {bus.in_ready, bus.out_valid, bus.result, bus.cout, bus.ovf, bus.zero};
    n_total++;
    if (got !== {1'b1, 1'b0, {W{1'b0}}, 3'b000})
      $display("FAIL reset_state: got %h expected %h", got, {1'b1, 1'b0, {W{1'b0}}, 3'b000});
    else n_pass++;
    // Reset wins over a simultaneous in_valid.
    bus.in_valid = 1'b1;
    bus.op_a     = 20'h00001;
    bus.op_b     = 20'h00001;
    tick();
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_priority: in_ready got %b expected 1", bus.in_ready);
    else n_pass++;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // One operation with its expected {result, cout, ovf, zero} and latency 4.
  task automatic run_case(input string name, input logic m, input logic [W-1:0] b,
                          input logic [W-1:0] a, input logic [W+2:0] exp);
    int lat;
    logic [W+2:0] got;
    do_op(m, b, a, lat);
    n_total++;
    if (lat !== 4) $display("FAIL %s_latency: got %0d expected 4", name, lat);
    else n_pass++;
    got = {bus.result, bus.cout, bus.ovf, bus.zero};
    n_total++;
    if (got !== exp)
      $display("FAIL %s_result: got res=%h c/o/z=%b expected res=%h c/o/z=%b",
               name, got[W+2:3], got[2:0], exp[W+2:3], exp[2:0]);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL %s_ready_in_done: in_ready got %b expected 0", name, bus.in_ready);
    else n_pass++;
    release_result();
  endtask

  task automatic test_add();
    run_case("add", 1'b0, 20'h00005, 20'h00003, {20'h00008, 3'b000});
  endtask

  task automatic test_sub();
    run_case("sub_neg", 1'b1, 20'h00003, 20'h00005, {20'hFFFFE, 3'b000});
    run_case("sub_eq", 1'b1, 20'h12345, 20'h12345, {20'h00000, 3'b101});
  endtask

  task automatic test_overflow();
`ifdef SEQ_ADDSUB_SATURATE_EN
    run_case("ovf_pos", 1'b0, 20'h7FFFF, 20'h00001, {20'h7FFFF, 3'b010});
    run_case("ovf_neg", 1'b0, 20'h80000, 20'h80000, {20'h80000, 3'b110});
`else
    run_case("ovf_pos", 1'b0, 20'h7FFFF, 20'h00001, {20'h80000, 3'b010});
    run_case("ovf_neg", 1'b0, 20'h80000, 20'h80000, {20'h00000, 3'b111});
`endif
  endtask

  task automatic test_abort();
    bit seen;
    bus.mode     = 1'b0;
    bus.op_b     = 20'h00001;
    bus.op_a     = 20'h00001;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready);
    else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.result !== 20'h00000) $display("FAIL abort_result: got %h expected 00000", bus.result);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL abort_no_result: out_valid seen %b expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+2:0] got;
    do_op(1'b0, 20'h00014, 20'h0000A, lat);
    // Offer a new operation while the result is held.
    bus.mode     = 1'b1;
    bus.op_b     = 20'h00010;
    bus.op_a     = 20'h00001;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    got = {bus.result, bus.cout, bus.ovf, bus.zero};
    n_total++;
    if (got !== {20'h0001E, 3'b000})
      $display("FAIL hold_result: got %h expected %h", got, {20'h0001E, 3'b000});
    else n_pass++;
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10)
      $display("FAIL hold_handshake: valid/ready got %b expected 10", {bus.out_valid, bus.in_ready});
    else n_pass++;
    release_result();
    n_total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL release_idle: valid/ready got %b expected 01", {bus.out_valid, bus.in_ready});
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL second_accept: in_ready got %b expected 0", bus.in_ready);
    else n_pass++;
    wait_done(lat);
    n_total++;
    if (lat !== 4) $display("FAIL second_latency: got %0d expected 4", lat);
    else n_pass++;
    got = {bus.result, bus.cout, bus.ovf, bus.zero};
    n_total++;
    if (got !== {20'h0000F, 3'b100})
      $display("FAIL second_result: got %h expected %h", got, {20'h0000F, 3'b100});
    else n_pass++;
    release_result();
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_abort();
    test_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 20, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 5, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operands and mode present.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port mode  input  1  0 = add (op_b + op_a), 1 = subtract (op_b - op_a).
REQ-008 SHALL have port op_a  input  WIDTH  addend / subtrahend.
REQ-009 SHALL have port op_b  input  WIDTH  addend / minuend.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  WIDTH  sum or difference.
REQ-013 SHALL have port cout  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  result equals 0.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 in IDLE: in_ready=1; in_valid=1 SHALL latch mode, op_a, op_b and go to RUN, chunk counter = 0, carry = mode.
REQ-018 subtract SHALL compute op_b + ~op_a + 1 (carry-in 1); add SHALL use carry-in 0.
REQ-019 in RUN: each cycle SHALL add one CHUNK slice (LSB slice first) with running carry, write that result slice, increment counter.
REQ-020 after slice WIDTH/CHUNK-1 SHALL go to DONE; out_valid SHALL rise exactly WIDTH/CHUNK cycles after the accepting edge (4 for defaults).
REQ-021 in DONE: out_valid=1; result, cout, ovf, zero SHALL be stable until the edge where out_ready=1, then go to IDLE.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored with no state change.
REQ-023 ovf SHALL be 1 when latched op_b and effective second operand (op_a, or ~op_a for subtract) share a sign bit differing from result MSB.
REQ-024 zero SHALL be computed on the final result, after any saturation.
REQ-025 carry out of the final slice SHALL be cout; counter SHALL not wrap past WIDTH/CHUNK-1.
REQ-026 out_valid and in_ready SHALL never both be 1.

Reset
REQ-027 rst=1 SHALL force IDLE on the next edge from any state, including mid-RUN, abandoning the operation.
REQ-028 after reset: in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, counter=0.
REQ-029 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-030 macro SEQ_ADDSUB_SATURATE_EN defined: on ovf=1 result SHALL clamp to max positive (0x7FFFF at 20 bits) when op_b is non-negative, else max negative (0x80000); ovf still reports 1; clamp applied on DONE entry, no extra cycle.
REQ-031 macro undefined: result SHALL be the modulo-2^WIDTH wrapped value; no clamp logic present.

Verification (WIDTH=20, CHUNK=5)
REQ-032 add op_b=0x00005, op_a=0x00003 -> result 0x00008, cout 0, ovf 0, zero 0, out_valid 4 cycles after accept.
REQ-033 sub op_b=0x00003, op_a=0x00005 -> result 0xFFFFE, cout 0, ovf 0, zero 0.
REQ-034 sub op_b=op_a=0x12345 -> result 0x00000, cout 1, zero 1, ovf 0.
REQ-035 add op_b=0x7FFFF, op_a=0x00001 -> ovf 1; result 0x80000 without macro, 0x7FFFF with SEQ_ADDSUB_SATURATE_EN.
REQ-036 rst=1 two cycles after accept -> next cycle in_ready 1, out_valid 0, result 0; no out_valid from abandoned operation.
REQ-037 out_ready held 0 for 3 cycles in DONE with in_valid=1 -> result and flags unchanged, in_ready 0, new operands not captured; accept occurs only after out_ready=1 returns FSM to IDLE.
